// File: rtl/unidade_controle_seq_if.sv
// Control bundle between the instruction sequencer and the 9-bit processor datapath.
// The sequencer is the master: it receives Run/IR/G_nz and drives every strobe.
interface unidade_controle_seq_if;
    logic       Run;
    logic [8:0] IR;
    logic       G_nz;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       Gout;
    logic       DINout;
    logic       Ain;
    logic       Gin;
    logic       AddSub;
    logic       ADDRin;
    logic       DOUTin;
    logic       W_D;
    logic       Done;
    logic [2:0] Tstep;

    modport master (
        input  Run, IR, G_nz,
        output IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub,
               ADDRin, DOUTin, W_D, Done, Tstep
    );

    modport slave (
        output Run, IR, G_nz,
        input  IRin, Rin, Rout, Gout, DINout, Ain, Gin, AddSub,
               ADDRin, DOUTin, W_D, Done, Tstep
    );
endinterface

// File: rtl/unidade_controle_seq.sv
// Multi-cycle instruction sequencer: a step counter plus combinational decode of
// (step, IR, G_nz) into the datapath strobes. IR is held externally, never latched here.
module unidade_controle_seq #(
    parameter int MEM_WAIT = 1
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    unidade_controle_seq_if.master  bus
);

    typedef enum logic [2:0] {
        T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
    } step_t;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_LD   = 3'b100;
    localparam logic [2:0] OP_ST   = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] LD_LAST = 3'(2 + MEM_WAIT);

    step_t      step_r;
    step_t      next_step_s;
    logic [2:0] op_s;
    logic [7:0] x_hot_s;
    logic [7:0] y_hot_s;
    logic [2:0] last_s;

    assign op_s      = bus.IR[8:6];
    assign x_hot_s   = 8'b0000_0001 << bus.IR[5:3];
    assign y_hot_s   = 8'b0000_0001 << bus.IR[2:0];
    assign bus.Tstep = step_r;

    // Step counter; the only state in the block.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            step_r <= T0;
        end else begin
            step_r <= next_step_s;
        end
    end

    // Final step of each opcode, used to recover from an out-of-range step.
    always_comb begin
        case (op_s)
            OP_ADD, OP_SUB: last_s = 3'd3;
            OP_LD:          last_s = LD_LAST;
            OP_ST:          last_s = 3'd2;
            default:        last_s = 3'd1;
        endcase
    end

    // Strobe decode and next-step selection.
    always_comb begin
        bus.IRin    = 1'b0;
        bus.Rin     = 8'd0;
        bus.Rout    = 8'd0;
        bus.Gout    = 1'b0;
        bus.DINout  = 1'b0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.AddSub  = 1'b0;
        bus.ADDRin  = 1'b0;
        bus.DOUTin  = 1'b0;
        bus.W_D     = 1'b0;
        bus.Done    = 1'b0;
        next_step_s = step_r;

        if (!Resetn) begin
            next_step_s = T0;
        end else if (step_r == T0) begin
            bus.IRin = bus.Run;
            if (bus.Run) begin
                next_step_s = T1;
            end else begin
                next_step_s = T0;
            end
        end else if (3'(step_r) > last_s) begin
            next_step_s = T0;
        end else begin
            case (op_s)
                OP_MV: begin
                    bus.Rout = y_hot_s;
                    bus.Rin  = x_hot_s;
                    bus.Done = 1'b1;
                end
                OP_MVI: begin
                    bus.DINout = 1'b1;
                    bus.Rin    = x_hot_s;
                    bus.Done   = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    case (step_r)
                        T1: begin
                            bus.Rout = x_hot_s;
                            bus.Ain  = 1'b1;
                        end
                        T2: begin
                            bus.Rout   = y_hot_s;
                            bus.Gin    = 1'b1;
                            bus.AddSub = (op_s == OP_SUB);
                        end
                        default: begin
                            bus.Gout = 1'b1;
                            bus.Rin  = x_hot_s;
                            bus.Done = 1'b1;
                        end
                    endcase
                end
                OP_LD: begin
                    if (step_r == T1) begin
                        bus.Rout   = y_hot_s;
                        bus.ADDRin = 1'b1;
                    end else if (3'(step_r) == LD_LAST) begin
                        bus.DINout = 1'b1;
                        bus.Rin    = x_hot_s;
                        bus.Done   = 1'b1;
                    end else begin
                        bus.Done = 1'b0;
                    end
                end
                OP_ST: begin
                    if (step_r == T1) begin
                        bus.Rout   = y_hot_s;
                        bus.ADDRin = 1'b1;
                    end else begin
                        bus.Rout   = x_hot_s;
                        bus.DOUTin = 1'b1;
                        bus.W_D    = 1'b1;
                        bus.Done   = 1'b1;
                    end
                end
                OP_MVNZ: begin
                    bus.Done = 1'b1;
                    if (bus.G_nz) begin
                        bus.Rout = y_hot_s;
                        bus.Rin  = x_hot_s;
                    end else begin
                        bus.Rout = 8'd0;
                    end
                end
                default: begin
                    bus.Done = 1'b1;
                end
            endcase

            if (bus.Done) begin
                next_step_s = T0;
            end else begin
                next_step_s = step_t'(3'(step_r) + 3'd1);
            end
        end
    end

endmodule

// File: tb/tb_unidade_controle_seq.sv
// Directed bench for the sequencer: two instances (MEM_WAIT=1 and MEM_WAIT=0) share
// one stimulus; each cycle the full {Tstep, strobes} word is compared to a hand value.
module tb_unidade_controle_seq;

    logic Clock;
    logic Resetn;
    logic       run;
    logic [8:0] ir;
    logic       g_nz;

    int vectors;
    int miscompares;

    unidade_controle_seq_if bus1 ();
    unidade_controle_seq_if bus0 ();

    assign bus1.Run  = run;
    assign bus1.IR   = ir;
    assign bus1.G_nz = g_nz;
    assign bus0.Run  = run;
    assign bus0.IR   = ir;
    assign bus0.G_nz = g_nz;

    unidade_controle_seq #(.MEM_WAIT(1)) dut1 (.Clock(Clock), .Resetn(Resetn), .bus(bus1));
    unidade_controle_seq #(.MEM_WAIT(0)) dut0 (.Clock(Clock), .Resetn(Resetn), .bus(bus0));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic [28:0] obs1;
    logic [28:0] obs0;
    assign obs1 = {bus1.Tstep, bus1.IRin, bus1.Rin, bus1.Rout, bus1.Gout, bus1.DINout,
                   bus1.Ain, bus1.Gin, bus1.AddSub, bus1.ADDRin, bus1.DOUTin, bus1.W_D, bus1.Done};
    assign obs0 = {bus0.Tstep, bus0.IRin, bus0.Rin, bus0.Rout, bus0.Gout, bus0.DINout,
                   bus0.Ain, bus0.Gin, bus0.AddSub, bus0.ADDRin, bus0.DOUTin, bus0.W_D, bus0.Done};

    // Expected word: t, irin, rin, rout, gout, dinout, ain, gin, addsub, addrin, doutin, wd, done
    function automatic logic [28:0] ev(input logic [2:0] t, input logic irin,
                                       input logic [7:0] rin, input logic [7:0] rout,
                                       input logic gout, input logic dinout, input logic ain,
                                       input logic gin, input logic addsub, input logic addrin,
                                       input logic doutin, input logic wd, input logic done);
        return {t, irin, rin, rout, gout, dinout, ain, gin, addsub, addrin, doutin, wd, done};
    endfunction

    task automatic check(input string tag, input logic [28:0] got, input logic [28:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to the next negedge, apply inputs, then sample 1ns later.
    task automatic step(input logic rn, input logic r, input logic [8:0] i, input logic g);
        @(negedge Clock);
        Resetn = rn;
        run    = r;
        ir     = i;
        g_nz   = g;
        #1;
    endtask

    localparam logic [28:0] IDLE = 29'd0;

    initial begin
        vectors     = 0;
        miscompares = 0;
        Resetn = 1'b0;
        run    = 1'b1;
        ir     = 9'd0;
        g_nz   = 1'b0;

        // Reset with Run held high: strobes forced low, then Tstep=0
        step(1'b0, 1'b1, 9'b000_000_000, 1'b0);
        check("rst_strobes", {3'd0, obs1[25:0]}, IDLE);
        step(1'b0, 1'b1, 9'b000_000_000, 1'b0);
        check("rst_state", obs1, IDLE);
        step(1'b1, 1'b0, 9'b000_000_000, 1'b0);
        check("idle_a", obs1, IDLE);
        step(1'b1, 1'b0, 9'b000_000_000, 1'b0);
        check("idle_b", obs1, IDLE);

        // mv R1,R2
        step(1'b1, 1'b1, 9'b000_001_010, 1'b0);
        check("mv_t0", obs1, ev(3'd0, 1'b1, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b000_001_010, 1'b0);
        check("mv_t1", obs1, ev(3'd1, 1'b0, 8'b0000_0010, 8'b0000_0100, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        step(1'b1, 1'b0, 9'b000_001_010, 1'b0);
        check("mv_end", obs1, IDLE);

        // sub R3,R4
        step(1'b1, 1'b1, 9'b011_011_100, 1'b0);
        check("sub_t0", obs1, ev(3'd0, 1'b1, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b011_011_100, 1'b0);
        check("sub_t1", obs1, ev(3'd1, 1'b0, 8'h00, 8'b0000_1000, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b011_011_100, 1'b0);
        check("sub_t2", obs1, ev(3'd2, 1'b0, 8'h00, 8'b0001_0000, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b011_011_100, 1'b0);
        check("sub_t3", obs1, ev(3'd3, 1'b0, 8'b0000_1000, 8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        step(1'b1, 1'b0, 9'b011_011_100, 1'b0);
        check("sub_end", obs1, IDLE);

        // ld R0,[R5] on both wait settings
        step(1'b1, 1'b1, 9'b100_000_101, 1'b0);
        check("ld1_t0", obs1, ev(3'd0, 1'b1, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b100_000_101, 1'b0);
        check("ld1_t1", obs1, ev(3'd1, 1'b0, 8'h00, 8'b0010_0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        check("ld0_t1", obs0, ev(3'd1, 1'b0, 8'h00, 8'b0010_0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b100_000_101, 1'b0);
        check("ld1_t2", obs1, ev(3'd2, 1'b0, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        check("ld0_t2", obs0, ev(3'd2, 1'b0, 8'b0000_0001, 8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        step(1'b1, 1'b0, 9'b100_000_101, 1'b0);
        check("ld1_t3", obs1, ev(3'd3, 1'b0, 8'b0000_0001, 8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        check("ld0_end", obs0, IDLE);
        step(1'b1, 1'b0, 9'b100_000_101, 1'b0);
        check("ld1_end", obs1, IDLE);

        // st R3,[R6]
        step(1'b1, 1'b1, 9'b101_011_110, 1'b0);
        step(1'b1, 1'b0, 9'b101_011_110, 1'b0);
        check("st_t1", obs1, ev(3'd1, 1'b0, 8'h00, 8'b0100_0000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b101_011_110, 1'b0);
        check("st_t2", obs1, ev(3'd2, 1'b0, 8'h00, 8'b0000_1000, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1));

        // mvnz R2,R1 with G_nz low then high
        step(1'b1, 1'b1, 9'b110_010_001, 1'b0);
        step(1'b1, 1'b0, 9'b110_010_001, 1'b0);
        check("mvnz_z", obs1, ev(3'd1, 1'b0, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        step(1'b1, 1'b1, 9'b110_010_001, 1'b1);
        step(1'b1, 1'b0, 9'b110_010_001, 1'b1);
        check("mvnz_nz", obs1, ev(3'd1, 1'b0, 8'b0000_0100, 8'b0000_0010, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));

        // Reserved opcode and back-to-back with Run held
        step(1'b1, 1'b1, 9'b111_101_011, 1'b0);
        step(1'b1, 1'b1, 9'b111_101_011, 1'b0);
        check("nop_t1", obs1, ev(3'd1, 1'b0, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));
        step(1'b1, 1'b1, 9'b001_111_000, 1'b0);
        check("b2b_t0", obs1, ev(3'd0, 1'b1, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b001_111_000, 1'b0);
        check("mvi_t1", obs1, ev(3'd1, 1'b0, 8'b1000_0000, 8'h00, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));

        // add R1,R2 with Run dropped in T1: still completes
        step(1'b1, 1'b1, 9'b010_001_010, 1'b0);
        step(1'b1, 1'b0, 9'b010_001_010, 1'b0);
        check("add_t1", obs1, ev(3'd1, 1'b0, 8'h00, 8'b0000_0010, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b010_001_010, 1'b0);
        check("add_t2", obs1, ev(3'd2, 1'b0, 8'h00, 8'b0000_0100, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b010_001_010, 1'b0);
        check("add_t3", obs1, ev(3'd3, 1'b0, 8'b0000_0010, 8'h00, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1));

        // add aborted by reset in T2
        step(1'b1, 1'b1, 9'b010_001_010, 1'b0);
        step(1'b1, 1'b0, 9'b010_001_010, 1'b0);
        step(1'b0, 1'b0, 9'b010_001_010, 1'b0);
        check("abort_t2", obs1, ev(3'd2, 1'b0, 8'h00, 8'h00, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0));
        step(1'b1, 1'b0, 9'b010_001_010, 1'b0);
        check("abort_t0", obs1, IDLE);
        step(1'b1, 1'b0, 9'b010_001_010, 1'b0);
        check("abort_hold", obs1, IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/unidade_controle_seq.md
Name: unidade_controle_seq

Overview:
- Multi-cycle instruction sequencer for the 9-bit simple processor.
- Holds its own 3-bit step counter (T0..T5) and decodes the externally held instruction register (IR). Drives every datapath control strobe: register file in/out enables, A/G registers, ALU mode, bus source select and memory address/data/write.
- Run/Done handshake with the top level; one instruction per Run-initiated sequence.

Parameters:
MEM_WAIT, 1, idle steps between ADDRin and DIN capture on ld; legal range 0..2.

Ports:
Clock  in  1  system clock, all state on posedge
Resetn  in  1  synchronous, active-low reset
Run  in  1  start request, sampled only in T0
IR  in  9  instruction: IR[8:6] opcode, IR[5:3] X, IR[2:0] Y
G_nz  in  1  G register non-zero flag (for mvnz)
IRin  out  1  load IR from DIN
Rin  out  8  one-hot register write enable R0..R7
Rout  out  8  one-hot register bus drive R0..R7
Gout  out  1  G drives bus
DINout  out  1  DIN drives bus
Ain  out  1  load A
Gin  out  1  load G with ALU result
AddSub  out  1  0=add, 1=sub
ADDRin  out  1  load memory address register
DOUTin  out  1  load memory data-out register
W_D  out  1  memory write enable
Done  out  1  final step of current instruction
Tstep  out  3  current step, debug/visibility

Behaviour:
- Reset: Resetn=0 at posedge sets Tstep=0. While Resetn=0 all control outputs are forced to 0 combinationally.
- Control outputs are combinational from (Tstep, IR, G_nz). Tstep is the only state.
- T0: IRin=Run. If Run=1, go to T1 at the next edge; otherwise stay in T0. No other strobe is active in T0.
- Run is ignored outside T0. Deasserting it mid-instruction does not abort.
- When Done=1, the next edge returns Tstep to 0. Otherwise Tstep increments by 1.
- Rin/Rout one-hot decode: Rin[X] or Rout[X] from IR[5:3], Rout[Y] from IR[2:0].
- Opcode sequences (steps after T0):
  - 000 mv Rx,Ry: T1 Rout[Y], Rin[X], Done.
  - 001 mvi Rx,#D: T1 DINout, Rin[X], Done. The immediate word is present on DIN in T1.
  - 010 add: T1 Rout[X], Ain; T2 Rout[Y], Gin, AddSub=0; T3 Gout, Rin[X], Done.
  - 011 sub: same as add, with AddSub=1 in T2.
  - 100 ld Rx,[Ry]: T1 Rout[Y], ADDRin; then MEM_WAIT idle steps; then DINout, Rin[X], Done. The final step is T(2+MEM_WAIT).
  - 101 st Rx,[Ry]: T1 Rout[Y], ADDRin; T2 Rout[X], DOUTin, W_D, Done.
  - 110 mvnz Rx,Ry: T1 Done. Rout[Y] and Rin[X] are asserted only if G_nz=1.
  - 111 reserved: T1 Done only (NOP).
- Invariant: at most one of {Rout[*], Gout, DINout} is asserted in any cycle (single bus driver).
- Invariant: Rin has at most one bit set.
- Tstep never exceeds 4 (ld with MEM_WAIT=2). The counter wraps only via Done.
- AddSub is 0 in every step except sub T2.
- IR must be stable from the T0→T1 edge until Done. The block does not latch IR.
- Reset mid-instruction: the next edge returns to T0. Strobes are 0 while Resetn=0, and no further steps of the aborted instruction occur.
- Run=1 held continuously executes back-to-back instructions. T0 occurs for exactly one cycle between them, with IRin=1.

Test Plan:
1. Reset with Resetn=0 for 2 cycles, Run=1 → Tstep=0, all strobes 0. After release with Run=0, stays in T0 with IRin=0.
2. IR=000_001_010 (mv R1,R2), Run pulse → T1: Rout=8'b00000100, Rin=8'b00000010, Done=1. Next cycle Tstep=0.
3. IR=011_011_100 (sub R3,R4) → T1 Rout[3], Ain; T2 Rout[4], Gin, AddSub=1; T3 Gout, Rin[3], Done. Total 4 cycles including T0.
4. IR=100_000_101 (ld R0,[R5]) → with MEM_WAIT=1, ADDRin in T1, idle T2, DINout and Rin[0] with Done in T3. Repeat with MEM_WAIT=0: Done in T2.
5. IR=110_010_001 (mvnz R2,R1) with G_nz=0 → T1 Done, Rin=0, Rout=0. With G_nz=1 → Rout[1], Rin[2], Done.
6. Start add, drop Run in T1 → instruction still completes at T3. Then start add and assert Resetn=0 in T2 → strobes 0 immediately, Tstep=0 after the edge, Rin never pulses.
